// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and request type for the write-back port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] res;
    } wb_req_t;

endpackage

// File: rtl/wb_pend_buf.sv
// One-entry valid/ready holding buffer for a long-latency result,
// plus the counter of consecutive cycles it has been denied a port.
module wb_pend_buf
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_cap_valid,
    input  logic [REGW-1:0]                 i_cap_rd,
    input  logic [XLEN-1:0]                 i_cap_res,
    output logic                            o_ready,
    input  logic                            i_drain,
    input  logic                            i_starve_inc,
    output wb_req_t                         o_pend,
    output logic [$clog2(STARVE_MAX+1)-1:0] o_starve_cnt
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    wb_req_t         r_pend;
    logic [CntW-1:0] r_starve_cnt;

    assign o_ready      = !r_pend.valid;
    assign o_pend       = r_pend;
    assign o_starve_cnt = r_starve_cnt;

    // Capture needs an empty buffer and drain needs a full one, so they never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
        end else if (i_cap_valid && !r_pend.valid) begin
            r_pend.valid <= 1'b1;
            r_pend.rd    <= i_cap_rd;
            r_pend.res   <= i_cap_res;
        end else if (i_drain) begin
            r_pend.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (i_starve_inc) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Maps two pipeline lanes and one buffered long-latency result onto the two
// register-file write ports, resolving WAW conflicts and starvation stalls.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lane0_valid,
    input  logic [REGW-1:0] lane0_rd,
    input  logic [XLEN-1:0] lane0_res,
    input  logic            lane1_valid,
    input  logic [REGW-1:0] lane1_rd,
    input  logic [XLEN-1:0] lane1_res,
    input  logic            ll_valid,
    input  logic [REGW-1:0] ll_rd,
    input  logic [XLEN-1:0] ll_res,
    output logic            ll_ready,
    output logic            we0,
    output logic [REGW-1:0] waddr0,
    output logic [XLEN-1:0] wdata0,
    output logic            we1,
    output logic [REGW-1:0] waddr1,
    output logic [XLEN-1:0] wdata1,
    output logic            pipe_stall
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    wb_req_t         w_pend;
    logic [CntW-1:0] w_starve_cnt;
    logic            w_e0, w_e1, w_ep;
    logic            w_wr0, w_wr1, w_both;
    logic            w_starved, w_pend_clash;
    logic            w_drain, w_starve_inc;

    wb_pend_buf #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pend_buf (
        .clk         (clk),
        .reset       (reset),
        .i_cap_valid (ll_valid),
        .i_cap_rd    (ll_rd),
        .i_cap_res   (ll_res),
        .o_ready     (ll_ready),
        .i_drain     (w_drain),
        .i_starve_inc(w_starve_inc),
        .o_pend      (w_pend),
        .o_starve_cnt(w_starve_cnt)
    );

    assign w_e0 = lane0_valid && (lane0_rd != '0);
    assign w_e1 = lane1_valid && (lane1_rd != '0);
    assign w_ep = w_pend.valid && (w_pend.rd != '0);

    // Lane 1 is the younger instruction, so it wins a same-rd conflict.
    assign w_wr0  = w_e0 && !(w_e1 && (lane0_rd == lane1_rd));
    assign w_wr1  = w_e1;
    assign w_both = w_wr0 && w_wr1;

    assign w_starved    = w_ep && w_both && (w_starve_cnt == CntW'(STARVE_MAX));
    assign w_pend_clash = (w_wr0 && (lane0_rd == w_pend.rd)) ||
                          (w_wr1 && (lane1_rd == w_pend.rd));

    // Every pending entry except a held one leaves this cycle, including x0 entries.
    assign w_drain      = w_pend.valid && !(w_ep && w_both && !w_starved);
    assign w_starve_inc = w_ep && w_both && !w_starved;

    always_comb begin
        we0        = w_wr0;
        waddr0     = lane0_rd;
        wdata0     = lane0_res;
        we1        = w_wr1;
        waddr1     = lane1_rd;
        wdata1     = lane1_res;
        pipe_stall = 1'b0;
        if (w_starved) begin
            pipe_stall = 1'b1;
            we0        = 1'b1;
            waddr0     = w_pend.rd;
            wdata0     = w_pend.res;
            we1        = 1'b0;
        end else if (w_ep && !w_both && !w_pend_clash) begin
            if (!w_wr0) begin
                we0    = 1'b1;
                waddr0 = w_pend.rd;
                wdata0 = w_pend.res;
            end else begin
                we1    = 1'b1;
                waddr1 = w_pend.rd;
                wdata1 = w_pend.res;
            end
        end
        if (reset) begin
            we0        = 1'b0;
            we1        = 1'b0;
            pipe_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with STARVE_MAX = 4.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            lane0_valid, lane1_valid, ll_valid;
    logic [REGW-1:0] lane0_rd, lane1_rd, ll_rd;
    logic [XLEN-1:0] lane0_res, lane1_res, ll_res;
    logic            ll_ready, we0, we1, pipe_stall;
    logic [REGW-1:0] waddr0, waddr1;
    logic [XLEN-1:0] wdata0, wdata1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .STARVE_MAX(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lane0_valid(lane0_valid),
        .lane0_rd   (lane0_rd),
        .lane0_res  (lane0_res),
        .lane1_valid(lane1_valid),
        .lane1_rd   (lane1_rd),
        .lane1_res  (lane1_res),
        .ll_valid   (ll_valid),
        .ll_rd      (ll_rd),
        .ll_res     (ll_res),
        .ll_ready   (ll_ready),
        .we0        (we0),
        .waddr0     (waddr0),
        .wdata0     (wdata0),
        .we1        (we1),
        .waddr1     (waddr1),
        .wdata1     (wdata1),
        .pipe_stall (pipe_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lane0_valid = 0; lane0_rd = '0; lane0_res = '0;
        lane1_valid = 0; lane1_rd = '0; lane1_res = '0;
        ll_valid    = 0; ll_rd    = '0; ll_res    = '0;
    endtask

    task automatic lanes(input logic v0, input logic [REGW-1:0] rd0, input logic [XLEN-1:0] r0,
                         input logic v1, input logic [REGW-1:0] rd1, input logic [XLEN-1:0] r1);
        lane0_valid = v0; lane0_rd = rd0; lane0_res = r0;
        lane1_valid = v1; lane1_rd = rd1; lane1_res = r1;
    endtask

    task automatic capture(input logic [REGW-1:0] rd, input logic [XLEN-1:0] res);
        ll_valid = 1; ll_rd = rd; ll_res = res;
        #4;
        chk("cap_ready", ll_ready, 1);
        tick();
        ll_valid = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        lane0_valid = 1; lane0_rd = 5'd3; lane0_res = 32'h1;
        #23;
        chk("rst_we0", we0, 0);
        chk("rst_we1", we1, 0);
        chk("rst_stall", pipe_stall, 0);
        chk("rst_ready", ll_ready, 1);
        tick();
        reset = 0;
        idle();

        // Single lane plus pending; capture cycle itself must not write the result.
        ll_valid = 1; ll_rd = 5'd7; ll_res = 32'h22;
        #4;
        chk("lat_we0", we0, 0);
        chk("lat_we1", we1, 0);
        tick();
        ll_valid = 0;
        lanes(1, 5'd3, 32'h11, 0, 5'd0, 32'h0);
        #4;
        chk("sp_ready", ll_ready, 0);
        chk("sp_we0", we0, 1);
        chk("sp_waddr0", waddr0, 3);
        chk("sp_wdata0", wdata0, 32'h11);
        chk("sp_we1", we1, 1);
        chk("sp_waddr1", waddr1, 7);
        chk("sp_wdata1", wdata1, 32'h22);
        chk("sp_stall", pipe_stall, 0);
        tick();
        idle();
        #4;
        chk("sp_ready_next", ll_ready, 1);
        chk("sp_idle_we1", we1, 0);
        tick();

        // Lane WAW.
        lanes(1, 5'd4, 32'h1, 1, 5'd4, 32'h2);
        #4;
        chk("waw_we0", we0, 0);
        chk("waw_we1", we1, 1);
        chk("waw_waddr1", waddr1, 4);
        chk("waw_wdata1", wdata1, 32'h2);
        tick();
        idle();

        // Lane 1 only plus pending: pending takes the free port 0.
        capture(5'd10, 32'h44);
        lanes(0, 5'd0, 32'h0, 1, 5'd11, 32'h55);
        #4;
        chk("l1p_we0", we0, 1);
        chk("l1p_waddr0", waddr0, 10);
        chk("l1p_wdata0", wdata0, 32'h44);
        chk("l1p_waddr1", waddr1, 11);
        tick();
        idle();

        // Starvation: four held cycles, stall on the fifth, lanes replayed after.
        capture(5'd9, 32'h99);
        lanes(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2);
        for (int i = 0; i < 4; i++) begin
            #4;
            chk("stv_hold_stall", pipe_stall, 0);
            chk("stv_hold_waddr0", {31'd0, we0} << 8 | waddr0, 32'h101);
            chk("stv_hold_waddr1", {31'd0, we1} << 8 | waddr1, 32'h102);
            chk("stv_hold_ready", ll_ready, 0);
            tick();
        end
        #4;
        chk("stv_stall", pipe_stall, 1);
        chk("stv_we0", we0, 1);
        chk("stv_waddr0", waddr0, 9);
        chk("stv_wdata0", wdata0, 32'h99);
        chk("stv_we1", we1, 0);
        tick();
        #4;
        chk("stv_after_stall", pipe_stall, 0);
        chk("stv_after_we0", we0, 1);
        chk("stv_after_waddr0", waddr0, 1);
        chk("stv_after_we1", we1, 1);
        chk("stv_after_waddr1", waddr1, 2);
        chk("stv_after_ready", ll_ready, 1);
        tick();
        idle();

        // x0 filtering.
        capture(5'd0, 32'h33);
        lanes(0, 5'd0, 32'h0, 1, 5'd0, 32'h77);
        #4;
        chk("x0_we0", we0, 0);
        chk("x0_we1", we1, 0);
        chk("x0_ready", ll_ready, 0);
        tick();
        idle();
        #4;
        chk("x0_dropped", ll_ready, 1);
        tick();

        // Pending versus lane WAW: the younger lane write wins.
        capture(5'd6, 32'h77);
        lanes(0, 5'd0, 32'h0, 1, 5'd6, 32'h5);
        #4;
        chk("pw_we0", we0, 0);
        chk("pw_we1", we1, 1);
        chk("pw_waddr1", waddr1, 6);
        chk("pw_wdata1", wdata1, 32'h5);
        tick();
        idle();
        #4;
        chk("pw_cleared", ll_ready, 1);
        chk("pw_idle_we0", we0, 0);
        tick();

        // Reset mid-operation discards the pending x5 result.
        capture(5'd5, 32'hAA);
        #2;
        reset = 1;
        lanes(1, 5'd8, 32'h8, 0, 5'd0, 32'h0);
        #2;
        chk("rm_we0", we0, 0);
        chk("rm_we1", we1, 0);
        chk("rm_ready", ll_ready, 1);
        tick();
        reset = 0;
        idle();
        #4;
        chk("rm_no_x5_we0", we0, 0);
        chk("rm_no_x5_we1", we1, 0);
        chk("rm_ready_after", ll_ready, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the two register-file write ports between the two EX→WB pipeline lanes and one long-latency result source (mul/div or load unit).
- Sits between the EX→WB pipeline register outputs and the register file.
- Buffers one long-latency result, resolves same-cycle write-after-write conflicts, and raises a pipeline stall when the long-latency result has waited too long.

Parameters:
- XLEN, 32, data width of results.
- REGW, 5, register index width.
- STARVE_MAX, 4, consecutive cycles a pending long-latency result may be denied a port before the pipeline is stalled.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- lane0_valid  in  1  lane 0 result valid (older instruction).
- lane0_rd  in  REGW  lane 0 destination register.
- lane0_res  in  XLEN  lane 0 result.
- lane1_valid  in  1  lane 1 result valid (younger instruction).
- lane1_rd  in  REGW  lane 1 destination register.
- lane1_res  in  XLEN  lane 1 result.
- ll_valid  in  1  long-latency result offered.
- ll_rd  in  REGW  long-latency destination register.
- ll_res  in  XLEN  long-latency result.
- ll_ready  out  1  long-latency result accepted this cycle.
- we0  out  1  write-port 0 enable.
- waddr0  out  REGW  write-port 0 address.
- wdata0  out  XLEN  write-port 0 data.
- we1  out  1  write-port 1 enable.
- waddr1  out  REGW  write-port 1 address.
- wdata1  out  XLEN  write-port 1 data.
- pipe_stall  out  1  drives the EX→WB register stall input and upstream stall.

Behaviour:
- State:
  - pend_valid, pend_rd, pend_res: one-entry holding buffer.
  - starve_cnt: counter, width clog2(STARVE_MAX+1).
- Reset (asynchronous, active-high):
  - Clears pend_valid, pend_rd, pend_res and starve_cnt to 0.
  - While reset is asserted, we0, we1 and pipe_stall are forced to 0.
  - ll_ready is 1 out of reset.
  - A pending result present when reset asserts mid-operation is discarded.
- Effective valids:
  - e0 = lane0_valid && lane0_rd != 0.
  - e1 = lane1_valid && lane1_rd != 0.
  - ep = pend_valid && pend_rd != 0.
  - x0 writes are never issued.
  - A pending entry with pend_rd == 0 is dropped on the next clock.
- Lane WAW: if e0 && e1 && lane0_rd == lane1_rd, lane 0's write is suppressed and lane 1 wins.
- Capture handshake:
  - ll_ready = !pend_valid, combinational.
  - On ll_valid && ll_ready the buffer loads ll_rd/ll_res at the clock edge.
  - The captured result is written to the register file no earlier than the next cycle (1-cycle minimum latency).
  - A capture and a drain never happen in the same cycle.
- Port mapping (combinational, no added latency):
  - Lane 0 uses port 0, lane 1 uses port 1.
  - Port addresses and data pass lane values unchanged.
  - A pending write takes port 0 if port 0 is unused, otherwise port 1.
  - Unused ports have we = 0; waddr/wdata on unused ports are don't-care.
- Cycle cases, where n = number of lane writes after WAW suppression:
  - Case A, n < 2 and ep: pending result written on a free port; buffer cleared; starve_cnt <= 0.
  - Case B, n == 2, ep and starve_cnt < STARVE_MAX: lane writes proceed; pending result held; starve_cnt increments.
  - Case C, n == 2, ep and starve_cnt == STARVE_MAX:
    - pipe_stall = 1; both lane writes suppressed; pending result written on port 0.
    - Buffer cleared; starve_cnt <= 0.
    - The frozen EX→WB register re-presents the same lanes next cycle.
  - No pending result: starve_cnt <= 0 and pipe_stall = 0.
- Pending-versus-lane WAW: if the pending write would occur while a lane writes the same rd in the same cycle, the pending write is suppressed (the lane is younger) and the buffer is still cleared.
- pipe_stall is asserted only in case C and never in two consecutive cycles caused by the same pending entry.

Decomposition:
- Shared package: XLEN/REGW constants, and a wb_req_t struct {valid, rd, res} used for lanes and pending.
- One sub-module: wb_pend_buf, the one-entry valid/ready holding buffer with the starvation counter; the arbitration logic stays in the top.

Test Plan:
- Reset mid-operation:
  - Stimulus: capture ll_rd=5/ll_res=0xAA, assert reset before drain.
  - Required: pend cleared, no write of x5, ll_ready=1 after reset, we0=we1=0 during reset.
- Single lane plus pending:
  - Stimulus: lane0 rd=3 res=0x11, pending rd=7 res=0x22.
  - Required: port0 x3=0x11, port1 x7=0x22 same cycle, ll_ready=1 next cycle.
- Lane WAW:
  - Stimulus: lane0 rd=4 res=1, lane1 rd=4 res=2.
  - Required: we0=0, we1=1 x4=2.
- Starvation (STARVE_MAX=4):
  - Stimulus: both lanes valid every cycle with distinct rds, pending rd=9.
  - Required: 4 cycles of lane writes, 5th cycle pipe_stall=1, only port0 x9 written, lanes written the following cycle.
- x0 filtering:
  - Stimulus: lane1 rd=0, pending rd=0.
  - Required: no writes; pending dropped next clock.
- Pending versus lane WAW:
  - Stimulus: lane1 rd=6 res=0x5, pending rd=6, lane0 idle.
  - Required: only x6=0x5 written; buffer cleared.
